// File: rtl/keccak_pkg.sv
// Shared Keccak constants and types for the slice-serial rho stages.
// Both the forward rotate and the inverse stage read RHO_OFF from here.
package keccak_pkg;

  localparam int NSLICE = 64;
  localparam int NLANE  = 25;
  localparam int ZW     = $clog2(NSLICE);

  typedef logic [NLANE-1:0] slice_t;

  typedef enum logic {
    LOAD   = 1'b0,
    UNLOAD = 1'b1
  } state_t;

  // Rotation amount of lane i = x + 5*y
  localparam logic [ZW-1:0] RHO_OFF [NLANE] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  function automatic int idx(input int x, input int y);
    return x + 5 * y;
  endfunction

endpackage

// File: rtl/rho_unrotate.sv
// Inverse rho: buffers one slice-serial state (64 x 25 bits) and replays it
// with every lane shifted back by its rho offset. Half-duplex load/unload.
module rho_unrotate
  import keccak_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [24:0] in_slice,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_slice,
  output logic [5:0]  out_z,
  output logic        done
);

  state_t         state_reg;
  logic [ZW-1:0]  cnt_reg;
  slice_t         slice_mem [NSLICE];
  slice_t         rd_slice;

  logic unloading;
  logic in_fire;
  logic out_fire;
  logic last_cnt;

  assign unloading = (state_reg == UNLOAD);
  assign in_fire   = in_valid && !unloading;
  assign out_fire  = unloading && out_ready;
  assign last_cnt  = &cnt_reg;

  // One counter serves both phases: write index in LOAD, output z in UNLOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= LOAD;
      cnt_reg   <= '0;
      for (int k = 0; k < NSLICE; k++) begin
        slice_mem[k] <= '0;
      end
    end else if (in_fire) begin
      slice_mem[cnt_reg] <= in_slice;
      cnt_reg            <= cnt_reg + 1'b1;
      if (last_cnt) begin
        state_reg <= UNLOAD;
      end
    end else if (out_fire) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (last_cnt) begin
        state_reg <= LOAD;
      end
    end
  end

  // Lane i of output slice z lives in stored slice (z + off_i) mod 64.
  for (genvar gy = 0; gy < 5; gy++) begin : g_row
    for (genvar gx = 0; gx < 5; gx++) begin : g_col
      localparam int LANE = idx(gx, gy);
      logic [ZW-1:0] rd_addr;
      assign rd_addr        = cnt_reg + RHO_OFF[LANE];
      assign rd_slice[LANE] = slice_mem[rd_addr][LANE];
    end
  end

  assign in_ready  = !unloading;
  assign out_valid = unloading;
  assign out_z     = unloading ? cnt_reg : '0;
  assign out_slice = unloading ? rd_slice : '0;
  assign done      = out_fire && last_cnt;

endmodule

// File: tb/tb_rho_unrotate.sv
// Directed bench for rho_unrotate: impulse, round trip through a forward-rho
// model, back-pressure, input gaps, phase lockout and mid-load reset.
module tb_rho_unrotate;

  typedef logic [24:0] sl_t;

  localparam int OFF_TB [25] = '{
    0,  1,  62, 28, 27,
    36, 44, 6,  55, 20,
    3,  10, 43, 25, 39,
    41, 45, 15, 21, 8,
    18, 2,  61, 56, 14
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] in_slice = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [24:0] out_slice;
  logic [5:0]  out_z;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  rho_unrotate dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_slice  (in_slice),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_slice (out_slice),
    .out_z     (out_z),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Forward rho: lane i of slice z takes the original bit from z - off_i.
  function automatic void fwd_rho(input sl_t st [64], output sl_t rot [64]);
    for (int z = 0; z < 64; z++) begin
      for (int i = 0; i < 25; i++) begin
        rot[z][i] = st[(z - OFF_TB[i] + 64) % 64][i];
      end
    end
  endfunction

  // Feeds n slices; returns once the last one has been accepted.
  task automatic load(input sl_t d [64], input int n, input bit gap, output bit ready_ok);
    int z;
    int cyc;
    z = 0;
    cyc = 0;
    ready_ok = 1'b1;
    while (z < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (gap && (cyc % 2 == 0)) begin
        in_valid = 1'b0;
      end else begin
        if (in_ready !== 1'b1) ready_ok = 1'b0;
        in_valid = 1'b1;
        in_slice = d[z];
        z++;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic unload(input int stall_at, input int stall_len, input bit jam,
                        output sl_t got [64], output int n_acc, output int n_done,
                        output int done_z, output bit order_ok, output bit stall_ok,
                        output bit lock_ok);
    int   cyc;
    int   stalled;
    sl_t  snap_s;
    logic [5:0] snap_z;
    n_acc = 0; n_done = 0; done_z = -1; cyc = 0; stalled = 0;
    order_ok = 1'b1; stall_ok = 1'b1; lock_ok = 1'b1;
    snap_s = '0; snap_z = '0;
    for (int k = 0; k < 64; k++) got[k] = '0;
    while (n_acc < 64 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_z == 6'(stall_at) && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
        if (stalled == 1) begin
          snap_s = out_slice;
          snap_z = out_z;
        end else if (out_slice !== snap_s || out_z !== snap_z || out_valid !== 1'b1) begin
          stall_ok = 1'b0;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (jam) begin
        in_valid = 1'b1;
        in_slice = 25'($urandom);
        if (in_ready !== 1'b0) lock_ok = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (out_z !== 6'(n_acc)) order_ok = 1'b0;
        got[out_z] = out_slice;
        n_acc++;
        if (done === 1'b1) begin
          n_done++;
          done_z = int'(out_z);
        end
      end else if (done === 1'b1) begin
        n_done++;
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  sl_t imp [64];
  sl_t st  [64];
  sl_t st2 [64];
  sl_t rot [64];
  sl_t rot2 [64];
  sl_t junk [64];
  sl_t got [64];
  sl_t got_ref [64];
  int  n_acc, n_done, done_z;
  bit  order_ok, stall_ok, lock_ok, ready_ok;
  int  bad;

  initial begin
    for (int z = 0; z < 64; z++) begin
      imp[z]  = (z == 0) ? 25'h1FFFFFF : 25'h0;
      st[z]   = 25'($urandom);
      st2[z]  = 25'($urandom);
      junk[z] = 25'($urandom) | 25'h1;
    end
    fwd_rho(st, rot);
    fwd_rho(st2, rot2);

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_z", 32'(out_z), 32'd0);
    chk("rst_out_slice", 32'(out_slice), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("step: reset released");

    // Impulse
    load(imp, 64, 1'b0, ready_ok);
    chk("imp_ready", 32'(ready_ok), 32'd1);
    chk("imp_latency_valid", 32'(out_valid), 32'd1);
    chk("imp_latency_in_ready", 32'(in_ready), 32'd0);
    chk("imp_first_z", 32'(out_z), 32'd0);
    unload(-1, 0, 1'b0, got, n_acc, n_done, done_z, order_ok, stall_ok, lock_ok);
    chk("imp_z0", 32'(got[0]), 32'h0000001);
    chk("imp_z2", 32'(got[2]), 32'h0000004);
    chk("imp_z62", 32'(got[62]), 32'h0200000);
    chk("imp_z63", 32'(got[63]), 32'h0000002);
    chk("imp_n_acc", 32'(n_acc), 32'd64);
    chk("imp_after_in_ready", 32'(in_ready), 32'd1);
    $display("step: impulse done, %0d outputs", n_acc);

    // Round trip
    load(rot, 64, 1'b0, ready_ok);
    unload(-1, 0, 1'b0, got, n_acc, n_done, done_z, order_ok, stall_ok, lock_ok);
    bad = 0;
    for (int z = 0; z < 64; z++) begin
      chk($sformatf("rt_slice_%0d", z), 32'(got[z]), 32'(st[z]));
    end
    chk("rt_done_count", 32'(n_done), 32'd1);
    chk("rt_done_z", 32'(done_z), 32'd63);
    chk("rt_order", 32'(order_ok), 32'd1);
    $display("step: round trip done, done pulses %0d", n_done);

    // Back-pressure at z = 10 for 5 cycles
    load(rot, 64, 1'b0, ready_ok);
    unload(10, 5, 1'b0, got, n_acc, n_done, done_z, order_ok, stall_ok, lock_ok);
    bad = 0;
    for (int z = 0; z < 64; z++) if (got[z] !== st[z]) bad++;
    chk("bp_mismatched_slices", 32'(bad), 32'd0);
    chk("bp_stable", 32'(stall_ok), 32'd1);
    chk("bp_order", 32'(order_ok), 32'd1);
    chk("bp_n_acc", 32'(n_acc), 32'd64);
    chk("bp_done_count", 32'(n_done), 32'd1);
    $display("step: back-pressure done");

    // Input gaps: same state, same result expected
    load(rot, 64, 1'b1, ready_ok);
    chk("gap_ready", 32'(ready_ok), 32'd1);
    chk("gap_latency_valid", 32'(out_valid), 32'd1);
    unload(-1, 0, 1'b0, got, n_acc, n_done, done_z, order_ok, stall_ok, lock_ok);
    bad = 0;
    for (int z = 0; z < 64; z++) if (got[z] !== st[z]) bad++;
    chk("gap_mismatched_slices", 32'(bad), 32'd0);
    $display("step: input-gap load done");

    // Phase lockout: in_valid held with junk during unload
    load(rot2, 64, 1'b0, ready_ok);
    unload(-1, 0, 1'b1, got, n_acc, n_done, done_z, order_ok, stall_ok, lock_ok);
    bad = 0;
    for (int z = 0; z < 64; z++) if (got[z] !== st2[z]) bad++;
    chk("lock_in_ready_low", 32'(lock_ok), 32'd1);
    chk("lock_mismatched_slices", 32'(bad), 32'd0);
    load(rot, 64, 1'b0, ready_ok);
    unload(-1, 0, 1'b0, got, n_acc, n_done, done_z, order_ok, stall_ok, lock_ok);
    bad = 0;
    for (int z = 0; z < 64; z++) if (got[z] !== st[z]) bad++;
    chk("lock_next_state", 32'(bad), 32'd0);
    $display("step: phase lockout done");

    // Reset mid-load after 30 slices
    load(junk, 30, 1'b0, ready_ok);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load(rot2, 64, 1'b0, ready_ok);
    chk("mid_rst_latency_valid", 32'(out_valid), 32'd1);
    unload(-1, 0, 1'b0, got, n_acc, n_done, done_z, order_ok, stall_ok, lock_ok);
    bad = 0;
    for (int z = 0; z < 64; z++) if (got[z] !== st2[z]) bad++;
    chk("mid_rst_mismatched_slices", 32'(bad), 32'd0);
    chk("mid_rst_n_acc", 32'(n_acc), 32'd64);
    $display("step: mid-load reset done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rho_unrotate.md
Name: rho_unrotate

Overview:
- Inverse of the Keccak rho lane-rotation step, working on the same slice-serial state format as the forward rotate stage.
- Collects one 1600-bit state as 64 slices of 25 bits, in z order 0..63, into an internal 64x25 buffer.
- Emits the 64 un-rotated slices, z = 0..63, over a valid/ready stream.
- Sits on the decode/readback path after the forward rho stage; the round-trip result equals the pre-rho state.

Parameters:
- NSLICE, 64, slices per state (lane width); power of two; counter width is log2(NSLICE).
- NLANE, 25, lanes per slice; fixed at 25, not meant to be overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_slice holds a valid slice.
- in_ready  out  1  block accepts a slice this cycle.
- in_slice  in  25  rotated slice; bit i = lane i, where i = x + 5*y.
- out_valid  out  1  out_slice and out_z are valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_slice  out  25  un-rotated slice for index out_z.
- out_z  out  6  slice index of out_slice.
- done  out  1  one-cycle pulse when the last output slice (z = 63) is accepted.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - State = LOAD, counter = 0, buffer cleared to 0.
  - in_ready = 1, out_valid = 0, done = 0.
  - out_z = 0, out_slice = 0.
- LOAD state:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: buffer[cnt] <= in_slice, cnt <= cnt + 1.
  - After the transfer with cnt = 63: cnt wraps to 0, state -> UNLOAD.
  - out_valid rises on the next cycle, so latency from last input accept to first output valid is 1 cycle.
- UNLOAD state:
  - in_ready = 0; in_valid is ignored and no buffer write occurs.
  - out_valid = 1, out_z = cnt.
  - out_slice[i] = buffer[(cnt + RHO_OFF[i]) mod 64][i] for i = 0..24. This is a combinational read from the register array; the mod is natural 6-bit wrap.
  - On out_valid & out_ready: cnt <= cnt + 1.
  - At cnt = 63: done = 1 for that cycle, cnt wraps to 0, state -> LOAD.
  - in_ready = 1 on the following cycle.
- Back-pressure: while out_ready = 0, out_valid, out_z and out_slice stay stable; cnt does not advance.
- Input stalls: in_valid low in LOAD holds cnt; there is no timeout.
- No simultaneous load and unload: the block is half-duplex, with exactly 64 transfers per phase.
- Reset mid-operation, either phase: immediate return to reset values; a partial state is discarded and the next accepted slice is stored as z = 0.
- Rho offsets RHO_OFF[i] by lane i = x + 5*y:
  - i 0-4: 0, 1, 62, 28, 27
  - i 5-9: 36, 44, 6, 55, 20
  - i 10-14: 3, 10, 43, 25, 39
  - i 15-19: 41, 45, 15, 21, 8
  - i 20-24: 18, 2, 61, 56, 14
- Arithmetic: 6-bit unsigned, (z + off) mod 64; no other arithmetic.

Decomposition:
- Shared package keccak_pkg holds:
  - Constants NSLICE, NLANE.
  - The 25-entry RHO_OFF constant array.
  - The lane index function idx(x, y) = x + 5*y.
  - A slice_t typedef (25-bit) and a state enum {LOAD, UNLOAD}.
- The forward rotate stage uses the same offset table, which must not be duplicated locally.
- Single flat module; no sub-module is needed. The 25 parallel offset reads are a generate loop.

Test Plan:
- Impulse: load z=0 slice = 25'h1FFFFFF, z=1..63 = 0 -> out_z=0: 25'h0000001; out_z=2: 25'h0000004; out_z=62: 25'h0200000; out_z=63: 25'h0000002.
- Round trip: random 1600-bit state, forward-rho in the bench model, feed 64 slices -> all 64 out_slice values equal the original slices; done pulses exactly once, with out_z = 63.
- Back-pressure: drop out_ready for 5 cycles at out_z = 10 -> out_z, out_slice and out_valid stable; no skipped or repeated z; the total of 64 accepted outputs is unchanged.
- Input gaps: in_valid toggling 1/0 every cycle -> 64 accepts take 128 cycles; output matches the gap-free run.
- Phase lockout: hold in_valid = 1 with changing data during UNLOAD -> in_ready = 0 and outputs unaffected; the next state loads correctly after done.
- Reset mid-load after 30 slices -> in_ready = 1, out_valid = 0; a fresh 64-slice load produces correct output with no residue from the aborted load.
